// File: rtl/branch_issue_arbiter.sv
// branch_issue_arbiter: shares the single SIMT branch unit among the warps of
// an SM core. A round-robin arbiter picks one eligible warp per free output
// slot and the choice is captured in a registered valid/ready stage. A per-warp
// pending bit and an in-flight counter track branches until the branch unit
// reports completion.
module branch_issue_arbiter #(
  parameter int NUM_WARPS       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OP_W            = 4,
  localparam int WID_W          = $clog2(NUM_WARPS),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WARPS-1:0]            req_valid,
  input  logic [NUM_WARPS-1:0][31:0]      req_address,
  input  logic [NUM_WARPS-1:0][31:0]      req_pred,
  input  logic [NUM_WARPS-1:0][OP_W-1:0]  req_op,
  output logic [NUM_WARPS-1:0]            req_ready,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [31:0]                     m_address,
  output logic [31:0]                     m_pred,
  output logic [OP_W-1:0]                 m_op,
  output logic [WID_W-1:0]                m_warp_id,
  input  logic                            done_valid,
  input  logic [WID_W-1:0]                done_warp_id,
  output logic [NUM_WARPS-1:0]            warp_pending,
  output logic [CNT_W-1:0]                outstanding
);

  logic [WID_W-1:0]     rrPtr_q, rrPtr_d;
  logic [NUM_WARPS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tvalid_q, tvalid_d;
  logic [31:0]          address_q, address_d;
  logic [31:0]          pred_q, pred_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [WID_W-1:0]     warpId_q, warpId_d;

  logic [NUM_WARPS-1:0] eligible;
  logic [CNT_W:0]       inFlight;
  logic                 slotOpen;
  logic                 budgetOk;
  logic                 hit;
  logic                 grant;
  logic [WID_W-1:0]     grantIdx;
  logic [WID_W-1:0]     idx;
  logic                 transfer;
  logic                 doneAccept;

  // Round-robin pick of the first eligible warp at or after rrPtr; the held
  // slot counts against the in-flight budget, and grants are masked in reset.
  always_comb begin
    eligible = req_valid & ~pending_q;
    inFlight = {1'b0, count_q} + {{CNT_W{1'b0}}, tvalid_q};
    slotOpen = ~tvalid_q | m_tready;
    budgetOk = inFlight < (CNT_W+1)'(MAX_OUTSTANDING);
    hit      = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rrPtr_q + WID_W'(i);
      if (!hit && eligible[idx]) begin
        hit      = 1'b1;
        grantIdx = idx;
      end
    end
    grant     = rst_n & hit & slotOpen & budgetOk;
    req_ready = '0;
    if (grant) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Next-state for output slot, pending bits, in-flight count and pointer.
  always_comb begin
    transfer   = tvalid_q & m_tready;
    doneAccept = done_valid & pending_q[done_warp_id] & (count_q != '0);
    rrPtr_d    = rrPtr_q;
    pending_d  = pending_q;
    count_d    = count_q;
    tvalid_d   = tvalid_q;
    address_d  = address_q;
    pred_d     = pred_q;
    op_d       = op_q;
    warpId_d   = warpId_q;
    if (done_valid && pending_q[done_warp_id]) begin
      pending_d[done_warp_id] = 1'b0;
    end
    if (transfer && !doneAccept) begin
      count_d = count_q + CNT_W'(1);
    end else if (!transfer && doneAccept) begin
      count_d = count_q - CNT_W'(1);
    end
    if (transfer) begin
      tvalid_d = 1'b0;
    end
    if (grant) begin
      pending_d[grantIdx] = 1'b1;
      tvalid_d            = 1'b1;
      address_d           = req_address[grantIdx];
      pred_d              = req_pred[grantIdx];
      op_d                = req_op[grantIdx];
      warpId_d            = grantIdx;
      rrPtr_d             = grantIdx + WID_W'(1);
    end
  end

  // State registers; reset drops any request held in the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q   <= '0;
      pending_q <= '0;
      count_q   <= '0;
      tvalid_q  <= 1'b0;
      address_q <= '0;
      pred_q    <= '0;
      op_q      <= '0;
      warpId_q  <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      tvalid_q  <= tvalid_d;
      address_q <= address_d;
      pred_q    <= pred_d;
      op_q      <= op_d;
      warpId_q  <= warpId_d;
    end
  end

  assign m_tvalid     = tvalid_q;
  assign m_address    = address_q;
  assign m_pred       = pred_q;
  assign m_op         = op_q;
  assign m_warp_id    = warpId_q;
  assign warp_pending = pending_q;
  assign outstanding  = count_q;

`ifndef SYNTHESIS
  // Completions must match an in-flight branch of a pending warp.
  assert property (@(posedge clk) disable iff (!rst_n) done_valid |-> (count_q != '0));
  assert property (@(posedge clk) disable iff (!rst_n) done_valid |-> pending_q[done_warp_id]);
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(MAX_OUTSTANDING));
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_branch_issue_arbiter.sv
// tb_branch_issue_arbiter: randomized stimulus against a queue-based model of
// the arbiter; granted requests go to a scoreboard that a negedge monitor
// drains whenever the DUT transfers to the branch unit.
module tb_branch_issue_arbiter;

  localparam int NW   = 32;
  localparam int MAXO = 4;
  localparam int OPW  = 4;
  localparam int WW   = 5;
  localparam int CW   = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NW-1:0]            req_valid;
  logic [NW-1:0][31:0]      req_address;
  logic [NW-1:0][31:0]      req_pred;
  logic [NW-1:0][OPW-1:0]   req_op;
  logic [NW-1:0]            req_ready;
  logic                     m_tvalid;
  logic                     m_tready;
  logic [31:0]              m_address;
  logic [31:0]              m_pred;
  logic [OPW-1:0]           m_op;
  logic [WW-1:0]            m_warp_id;
  logic                     done_valid;
  logic [WW-1:0]            done_warp_id;
  logic [NW-1:0]            warp_pending;
  logic [CW-1:0]            outstanding;

  branch_issue_arbiter #(
    .NUM_WARPS      (NW),
    .MAX_OUTSTANDING(MAXO),
    .OP_W           (OPW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_address (req_address),
    .req_pred    (req_pred),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_address   (m_address),
    .m_pred      (m_pred),
    .m_op        (m_op),
    .m_warp_id   (m_warp_id),
    .done_valid  (done_valid),
    .done_warp_id(done_warp_id),
    .warp_pending(warp_pending),
    .outstanding (outstanding)
  );

  always #10 clk = ~clk;

  typedef struct {
    int           warp;
    logic [31:0]  addr;
    logic [31:0]  pred;
    logic [3:0]   op;
  } txn_t;

  txn_t sbQ[$];
  int   unitQ[$];
  bit   modelPend[NW];
  int   inflight;
  bit   held;
  int   heldWarp;
  int   rr;
  int   tests = 0;
  int   fails = 0;
  txn_t mon;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] pendVec();
    logic [NW-1:0] v;
    v = '0;
    for (int w = 0; w < NW; w++) v[w] = modelPend[w];
    return v;
  endfunction

  task automatic resetModel();
    for (int w = 0; w < NW; w++) modelPend[w] = 1'b0;
    inflight = 0;
    held     = 1'b0;
    heldWarp = 0;
    rr       = 0;
    sbQ.delete();
    unitQ.delete();
  endtask

  // Compare registered outputs and the grant against the model, then advance
  // the model to the state the DUT takes at the coming edge.
  task automatic checkOutput();
    logic [NW-1:0] expReady;
    int g;
    int w;
    check("m_tvalid", m_tvalid, held);
    if (held) check("m_warp_id", m_warp_id, heldWarp);
    check("warp_pending", warp_pending, pendVec());
    check("outstanding", outstanding, inflight);
    expReady = '0;
    g = -1;
    if ((!held || m_tready) && (inflight + int'(held) < MAXO)) begin
      for (int k = 0; k < NW; k++) begin
        w = (rr + k) % NW;
        if (g < 0 && req_valid[w] && !modelPend[w]) g = w;
      end
    end
    if (g >= 0) expReady[g] = 1'b1;
    check("req_ready", req_ready, expReady);
    if (held && m_tready) begin
      inflight++;
      unitQ.push_back(heldWarp);
      held = 1'b0;
    end
    if (done_valid) begin
      inflight--;
      modelPend[done_warp_id] = 1'b0;
    end
    if (g >= 0) begin
      modelPend[g] = 1'b1;
      held         = 1'b1;
      heldWarp     = g;
      rr           = (g + 1) % NW;
      sbQ.push_back('{g, req_address[g], req_pred[g], req_op[g]});
    end
  endtask

  // One clock of random stimulus restricted to the warps in mask.
  task automatic applyStimulus(input logic [NW-1:0] mask, input int reqProb,
                               input int trProb, input int doneProb);
    int idx;
    @(posedge clk);
    #2;
    for (int w = 0; w < NW; w++) begin
      req_valid[w]   = mask[w] && ($urandom_range(99) < reqProb);
      req_address[w] = $urandom;
      req_pred[w]    = $urandom;
      req_op[w]      = OPW'($urandom);
    end
    m_tready     = ($urandom_range(99) < trProb);
    done_valid   = 1'b0;
    done_warp_id = '0;
    if (unitQ.size() > 0 && $urandom_range(99) < doneProb) begin
      idx          = $urandom_range(unitQ.size() - 1);
      done_valid   = 1'b1;
      done_warp_id = WW'(unitQ[idx]);
      unitQ.delete(idx);
    end
    #1;
    checkOutput();
  endtask

  task automatic runPhase(input logic [NW-1:0] mask, input int reqProb, input int trProb,
                          input int doneProb, input int cycles);
    repeat (cycles) applyStimulus(mask, reqProb, trProb, doneProb);
  endtask

  // Assert reset away from the clock edge and verify outputs clear at once.
  task automatic doReset();
    req_valid  = '1;
    m_tready   = 1'b0;
    done_valid = 1'b0;
    done_warp_id = '0;
    rst_n = 1'b0;
    #1;
    check("rst m_tvalid", m_tvalid, 1'b0);
    check("rst outstanding", outstanding, '0);
    check("rst warp_pending", warp_pending, '0);
    check("rst req_ready", req_ready, '0);
    check("rst m_address", m_address, '0);
    check("rst m_pred", m_pred, '0);
    check("rst m_op", m_op, '0);
    check("rst m_warp_id", m_warp_id, '0);
    resetModel();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every transfer must match the oldest granted request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected transfer: warp %0d with empty scoreboard", m_warp_id);
      end else begin
        mon = sbQ.pop_front();
        check("xfer warp", m_warp_id, mon.warp);
        check("xfer addr", m_address, mon.addr);
        check("xfer pred", m_pred, mon.pred);
        check("xfer op", m_op, mon.op);
      end
    end
  end

  initial begin
    req_address = '0;
    req_pred    = '0;
    req_op      = '0;
    #1;
    doReset();

    // Single requester, immediate completions
    runPhase(32'h0000_0008, 100, 100, 100, 8);
    // Round-robin among 0, 5 and 31 with wrap
    runPhase(32'h8000_0021, 100, 100, 100, 30);
    // Backpressure, then release
    runPhase(32'h0000_0280, 100, 0, 0, 6);
    runPhase(32'h0000_0280, 100, 100, 100, 6);
    // Drain, then cap with six requesters and no completions
    runPhase('0, 0, 100, 100, 12);
    runPhase(32'h0000_3F00, 100, 100, 0, 12);
    runPhase(32'h0000_3F00, 100, 100, 100, 1);
    runPhase(32'h0000_3F00, 100, 100, 0, 6);
    runPhase('0, 0, 100, 100, 12);
    // Same-warp reissue
    runPhase(32'h0000_0004, 100, 100, 100, 12);
    // Broad random traffic
    runPhase('1, 50, 70, 40, 2000);

    // Build m_tvalid=1 with three in flight, then reset mid-cycle
    runPhase('0, 0, 100, 100, 12);
    runPhase(32'h0010_1210, 100, 100, 0, 4);
    @(posedge clk);
    #6;
    check("pre-reset m_tvalid", m_tvalid, 1'b1);
    check("pre-reset outstanding", outstanding, CW'(3));
    doReset();
    applyStimulus(32'h0010_1210, 100, 100, 0);
    check("first grant after reset", req_ready, 32'h0000_0010);
    runPhase('1, 60, 80, 50, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
